// File: rtl/imm_pkg.sv
// Shared definitions for the immediate path: the ExtOp encodings used by both
// the immediate extender and the constant encoder, and the encoder FSM states.
package imm_pkg;

    localparam int IMM_W    = 16;
    localparam int VALUE_W  = 32;
    localparam int EXTOP_W  = 2;

    // ExtOp encodings understood by the extender
    localparam logic [EXTOP_W-1:0] EXT_ZERO = 2'b00;  // imm zero-extended
    localparam logic [EXTOP_W-1:0] EXT_SIGN = 2'b01;  // imm sign-extended from bit 15
    localparam logic [EXTOP_W-1:0] EXT_HIGH = 2'b10;  // imm placed in bits 31:16

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } imm_state_e;

endpackage

// File: rtl/imm_enc_classify.sv
// Combinational classifier: picks the shortest extender encoding for a 32-bit
// constant and returns the first beat plus whether a second (low-half) beat is
// needed. The sign-extended single-beat form is only produced when
// IMM_ENC_SIGNED_EN is defined.
module imm_enc_classify
    import imm_pkg::*;
(
    input  logic [31:0] value,
    output logic        two_beat,
    output logic [15:0] first_imm,
    output logic [1:0]  first_extop
);

    // Priority-ordered encoding choice; the first matching form wins
    always_comb begin
        two_beat    = 1'b0;
        first_imm   = value[15:0];
        first_extop = EXT_ZERO;
        if (value[31:16] == 16'h0000) begin
            first_imm   = value[15:0];
            first_extop = EXT_ZERO;
        end
`ifdef IMM_ENC_SIGNED_EN
        else if (&value[31:15]) begin
            first_imm   = value[15:0];
            first_extop = EXT_SIGN;
        end
`endif
        else if (value[15:0] == 16'h0000) begin
            first_imm   = value[31:16];
            first_extop = EXT_HIGH;
        end
        else begin
            // high half first, the low half is OR-merged by the second beat
            two_beat    = 1'b1;
            first_imm   = value[31:16];
            first_extop = EXT_HIGH;
        end
    end

endmodule

// File: rtl/imm_encoder.sv
// Constant encoder for the immediate injection path. Accepts a 32-bit constant
// over valid/ready and emits one or two (imm, ExtOp) beats that the extender
// reproduces the constant from. All outputs are registered.
// Optional feature: define IMM_ENC_SIGNED_EN to enable sign-extended single beats.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a new constant, no beat pending
// BEAT0 | first beat held on the outputs until the consumer takes it
// BEAT1 | low-half beat of a two-beat encoding held on the outputs
module imm_encoder
    import imm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_imm,
    output logic [1:0]  out_extop,
    output logic        out_last
);

    imm_state_e  state_q, state_d;
    logic [15:0] val_lo_q, val_lo_d;
    logic [15:0] out_imm_q, out_imm_d;
    logic [1:0]  out_extop_q, out_extop_d;
    logic        out_last_q, out_last_d;
    logic        out_valid_q, out_valid_d;
    logic        in_ready_q, in_ready_d;

    logic        cls_two_beat;
    logic [15:0] cls_imm;
    logic [1:0]  cls_extop;

    // The classifier looks at in_value in the accept cycle, which is exactly
    // the value being captured, so the first beat is ready one cycle later.
    imm_enc_classify u_classify (
        .value       (in_value),
        .two_beat    (cls_two_beat),
        .first_imm   (cls_imm),
        .first_extop (cls_extop)
    );

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        val_lo_d    = val_lo_q;
        out_imm_d   = out_imm_q;
        out_extop_d = out_extop_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // only the low half is needed later, for the second beat
                    val_lo_d    = in_value[15:0];
                    out_imm_d   = cls_imm;
                    out_extop_d = cls_extop;
                    out_last_d  = ~cls_two_beat;
                    out_valid_d = 1'b1;
                    in_ready_d  = 1'b0;
                    state_d     = BEAT0;
                end
            end
            BEAT0: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        in_ready_d  = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        out_imm_d   = val_lo_q;
                        out_extop_d = EXT_ZERO;
                        out_last_d  = 1'b1;
                        state_d     = BEAT1;
                    end
                end
            end
            BEAT1: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State, captured value and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            val_lo_q    <= 16'h0000;
            out_imm_q   <= 16'h0000;
            out_extop_q <= EXT_ZERO;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            val_lo_q    <= val_lo_d;
            out_imm_q   <= out_imm_d;
            out_extop_q <= out_extop_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_imm   = out_imm_q;
    assign out_extop = out_extop_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed testbench for imm_encoder. Observed outputs are packed as
// {in_ready, out_valid, out_last, out_extop, out_imm} for compact comparison.
// Expectations for 32'hFFFF8000 follow the IMM_ENC_SIGNED_EN build setting.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_imm;
    logic [1:0]  out_extop;
    logic        out_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_extop (out_extop),
        .out_last  (out_last)
    );

    wire [20:0] obs = {in_ready, out_valid, out_last, out_extop, out_imm};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_value = 32'h0;
        step(); step();
        rst = 1'b0;
        step();
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 2'b00, 16'h0000}) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs, 21'h100000);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL idle_out_ready_ignored: got ready/valid %b expected 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_single_beat();
        logic [31:0] vals [5] = '{32'h00001234, 32'h12340000, 32'h00000000,
                                  32'h00008000, 32'h80000000};
        logic [17:0] exps [5] = '{{2'b00, 16'h1234}, {2'b10, 16'h1234}, {2'b00, 16'h0000},
                                  {2'b00, 16'h8000}, {2'b10, 16'h8000}};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_value = vals[i];
            step();
            in_valid = 1'b0; in_value = 32'hA5A5A5A5;
            checks++;
            if (obs !== {1'b0, 1'b1, 1'b1, exps[i]}) begin
                errors++;
                $display("FAIL single_beat[%0d] %h: got %h expected %h", i, vals[i], obs, {3'b011, exps[i]});
            end
            step();
            checks++;
            if ({in_ready, out_valid} !== 2'b10) begin
                errors++;
                $display("FAIL single_idle[%0d]: got ready/valid %b expected 10", i, {in_ready, out_valid});
            end
        end
    endtask

    task automatic test_two_beat();
        logic [31:0] vals [2] = '{32'hFFFF7FFF, 32'h00010001};
        logic [15:0] his  [2] = '{16'hFFFF, 16'h0001};
        logic [15:0] los  [2] = '{16'h7FFF, 16'h0001};
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_value = vals[i];
            step();
            in_valid = 1'b0; in_value = 32'h0;
            checks++;
            if (obs !== {1'b0, 1'b1, 1'b0, 2'b10, his[i]}) begin
                errors++;
                $display("FAIL two_beat_hi[%0d]: got %h expected %h", i, obs, {5'b01010, his[i]});
            end
            step();
            checks++;
            if (obs !== {1'b0, 1'b1, 1'b1, 2'b00, los[i]}) begin
                errors++;
                $display("FAIL two_beat_lo[%0d]: got %h expected %h", i, obs, {5'b01100, los[i]});
            end
            step();
            checks++;
            if ({in_ready, out_valid} !== 2'b10) begin
                errors++;
                $display("FAIL two_beat_idle[%0d]: got ready/valid %b expected 10", i, {in_ready, out_valid});
            end
        end
    endtask

    task automatic test_signed();
        out_ready = 1'b1;
        in_valid = 1'b1; in_value = 32'hFFFF8000;
        step();
        in_valid = 1'b0;
`ifdef IMM_ENC_SIGNED_EN
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b1, 2'b01, 16'h8000}) begin
            errors++;
            $display("FAIL signed_beat: got %h expected %h", obs, {5'b01101, 16'h8000});
        end
`else
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b0, 2'b10, 16'hFFFF}) begin
            errors++;
            $display("FAIL unsigned_hi: got %h expected %h", obs, {5'b01010, 16'hFFFF});
        end
        step();
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b1, 2'b00, 16'h8000}) begin
            errors++;
            $display("FAIL unsigned_lo: got %h expected %h", obs, {5'b01100, 16'h8000});
        end
`endif
        step();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL signed_idle: got ready/valid %b expected 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        in_valid = 1'b1; in_value = 32'hDEADBEEF;
        step();
        // a competing value offered while busy must be ignored
        in_value = 32'h5555AAAA;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs !== {1'b0, 1'b1, 1'b0, 2'b10, 16'hDEAD}) begin
                errors++;
                $display("FAIL hold_beat0[%0d]: got %h expected %h", c, obs, {5'b01010, 16'hDEAD});
            end
            if (c < 2) step();
        end
        step();
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b0, 2'b10, 16'hDEAD}) begin
            errors++;
            $display("FAIL hold_beat0_last: got %h expected %h", obs, {5'b01010, 16'hDEAD});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b1, 2'b00, 16'hBEEF}) begin
            errors++;
            $display("FAIL hold_beat1: got %h expected %h", obs, {5'b01100, 16'hBEEF});
        end
        step();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL hold_idle: got ready/valid %b expected 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid = 1'b1; in_value = 32'h00000011;
        step();
        in_value = 32'h22220000;
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b1, 2'b00, 16'h0011}) begin
            errors++;
            $display("FAIL b2b_first: got %h expected %h", obs, {5'b01100, 16'h0011});
        end
        step();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_gap: got ready/valid %b expected 10", {in_ready, out_valid});
        end
        step();
        in_value = 32'h00010002;
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b1, 2'b10, 16'h2222}) begin
            errors++;
            $display("FAIL b2b_second: got %h expected %h", obs, {5'b01110, 16'h2222});
        end
        step();
        step();
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b0, 2'b10, 16'h0001}) begin
            errors++;
            $display("FAIL b2b_two_hi: got %h expected %h", obs, {5'b01010, 16'h0001});
        end
        step();
        in_value = 32'h00000003;
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b1, 2'b00, 16'h0002}) begin
            errors++;
            $display("FAIL b2b_two_lo: got %h expected %h", obs, {5'b01100, 16'h0002});
        end
        step();
        step();
        in_valid = 1'b0;
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b1, 2'b00, 16'h0003}) begin
            errors++;
            $display("FAIL b2b_third: got %h expected %h", obs, {5'b01100, 16'h0003});
        end
        step();
    endtask

    task automatic test_reset_mid();
        // reset while in BEAT1
        out_ready = 1'b1;
        in_valid = 1'b1; in_value = 32'hCAFEF00D;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b1, 2'b00, 16'hF00D}) begin
            errors++;
            $display("FAIL rst_mid_beat1: got %h expected %h", obs, {5'b01100, 16'hF00D});
        end
        out_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 2'b00, 16'h0000}) begin
            errors++;
            $display("FAIL rst_mid_after_beat1: got %h expected %h", obs, 21'h100000);
        end
        // reset while in BEAT0
        in_valid = 1'b1; in_value = 32'h12345678;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 2'b00, 16'h0000}) begin
            errors++;
            $display("FAIL rst_mid_after_beat0: got %h expected %h", obs, 21'h100000);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_stray_beat: got out_valid %b expected 0", out_valid);
        end
        in_valid = 1'b1; in_value = 32'h00000000;
        step();
        in_valid = 1'b0;
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b1, 2'b00, 16'h0000}) begin
            errors++;
            $display("FAIL rst_then_zero: got %h expected %h", obs, {5'b01100, 16'h0000});
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_two_beat();
        test_signed();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
